// File: rtl/mips_alu_pkg.sv
// Shared constants for the MIPS ALU multiply path: funct codes, multiplier
// control codes, FSM state encoding and default widths.
package mips_alu_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int ITER_DEFAULT  = 32;

   localparam logic [5:0] MULTU    = 6'b011001;
   localparam logic [5:0] OUT      = 6'b111111;
   localparam logic [5:0] MFHI     = 6'b010000;
   localparam logic [5:0] MFLO     = 6'b010010;
   localparam logic [5:0] MTHI     = 6'b010001;
   localparam logic [5:0] MTLO     = 6'b010011;
   localparam logic [5:0] MUL_NOP  = 6'b000000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLR     = 3'd1,
      RUN     = 3'd2,
      DRAIN   = 3'd3,
      CAPTURE = 3'd4
   } state_t;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO result store: product capture, direct MTHI/MTLO writes and a read mux
// used for MFHI/MFLO.
module hilo_regs
   import mips_alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cap_en,
   input  logic [2*WIDTH-1:0]   cap_data,
   input  logic                 mt_hi_en,
   input  logic                 mt_lo_en,
   input  logic [WIDTH-1:0]     mt_data,
   input  logic                 rd_sel_hi,
   output logic [WIDTH-1:0]     hi,
   output logic [WIDTH-1:0]     lo,
   output logic [WIDTH-1:0]     rd_mux
);

   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (cap_en) begin
         hi <= cap_data[2*WIDTH-1:WIDTH];
         lo <= cap_data[WIDTH-1:0];
      end else begin
         if (mt_hi_en) hi <= mt_data;
         if (mt_lo_en) lo <= mt_data;
      end
   end

   assign rd_mux = rd_sel_hi ? hi : lo;

endmodule

// File: rtl/multu_hilo_ctrl.sv
// MULTU sequencer for the iterative shift-add multiplier plus HI/LO access.
// Build option: define MTHILO_EN to enable MTHI/MTLO writes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready; accepts MULTU, MFHI/MFLO (and MTHI/MTLO if enabled)
//   CLR     | one-cycle multiplier clear, operands already held
//   RUN     | ITER add/shift cycles, mul_signal=MULTU
//   DRAIN   | one cycle of mul_signal=OUT to present the product
//   CAPTURE | product written to HI/LO, done pulses next cycle
module multu_hilo_ctrl
   import mips_alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int ITER  = ITER_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic [5:0]           funct,
   input  logic [WIDTH-1:0]     opA,
   input  logic [WIDTH-1:0]     opB,
   output logic                 ready,
   output logic                 done,
   output logic [WIDTH-1:0]     rd_data,
   output logic                 rd_valid,
   output logic [WIDTH-1:0]     hi,
   output logic [WIDTH-1:0]     lo,
   output logic                 mul_reset,
   output logic [5:0]           mul_signal,
   output logic [WIDTH-1:0]     mul_dataA,
   output logic [WIDTH-1:0]     mul_dataB,
   input  logic [2*WIDTH-1:0]   mul_dataOut
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            accept;
   logic            cap_en;
   logic            mt_hi_en;
   logic            mt_lo_en;
   logic            rd_sel_hi;
   logic [WIDTH-1:0] rd_mux;

   assign ready     = (state == IDLE);
   assign mul_reset = reset | (state == CLR);
   assign accept    = req & ready;
   assign cap_en    = (state == CAPTURE);
   assign rd_sel_hi = (funct == MFHI);

`ifdef MTHILO_EN
   assign mt_hi_en = accept & (funct == MTHI);
   assign mt_lo_en = accept & (funct == MTLO);
`else
   assign mt_hi_en = 1'b0;
   assign mt_lo_en = 1'b0;
`endif

   hilo_regs #(.WIDTH(WIDTH)) u_hilo (
      .clk      (clk),
      .reset    (reset),
      .cap_en   (cap_en),
      .cap_data (mul_dataOut),
      .mt_hi_en (mt_hi_en),
      .mt_lo_en (mt_lo_en),
      .mt_data  (opA),
      .rd_sel_hi(rd_sel_hi),
      .hi       (hi),
      .lo       (lo),
      .rd_mux   (rd_mux)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         done       <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         mul_signal <= MUL_NOP;
         mul_dataA  <= '0;
         mul_dataB  <= '0;
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (funct == MULTU) begin
                     mul_dataA  <= opA;
                     mul_dataB  <= opB;
                     mul_signal <= MUL_NOP;
                     state      <= CLR;
                  end else if (funct == MFHI || funct == MFLO) begin
                     rd_data  <= rd_mux;
                     rd_valid <= 1'b1;
                  end
               end
            end
            CLR: begin
               cnt        <= '0;
               mul_signal <= MULTU;
               state      <= RUN;
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               // mul_signal is registered, so OUT is loaded on the last RUN edge
               if (cnt == CNT_LAST) begin
                  mul_signal <= OUT;
                  state      <= DRAIN;
               end
            end
            DRAIN: begin
               mul_signal <= MUL_NOP;
               state      <= CAPTURE;
            end
            CAPTURE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               mul_signal <= MUL_NOP;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/multu_hilo_ctrl.md
Name: multu_hilo_ctrl

Overview:
Sequencer and result store for the iterative 32x32 unsigned shift-add multiplier.
- Accepts MULTU requests from the decode stage and drives the multiplier's control code and operands through one full operation.
- Captures the 64-bit product into HI/LO and serves MFHI/MFLO reads.
- Sits between decode/ALU control (upstream) and the multiplier, whose dataOut it consumes.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each, product 2*WIDTH
ITER, 32, number of multiplier add/shift cycles per operation

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  1  request strobe, sampled only when ready=1
funct  in  6  operation code with req: MULTU=25, MFHI=16, MFLO=18
opA  in  WIDTH  multiplicand (MULTU)
opB  in  WIDTH  multiplier (MULTU)
ready  out  1  high in IDLE; request accepted on req&ready
done  out  1  one-cycle pulse when HI/LO updated by MULTU
rd_data  out  WIDTH  MFHI/MFLO result
rd_valid  out  1  one-cycle pulse, rd_data valid
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
mul_reset  out  1  clear pulse to multiplier
mul_signal  out  6  multiplier control code: 25=MULTU, 63=OUT, 0=idle
mul_dataA  out  WIDTH  held multiplicand
mul_dataB  out  WIDTH  held multiplier
mul_dataOut  in  2*WIDTH  product from multiplier

Behaviour:
- Single clock domain, synchronous active-high reset.
- Reset values: state=IDLE, hi=lo=0, rd_data=0, rd_valid=0, done=0, mul_signal=0, mul_dataA=mul_dataB=0, iteration counter=0.
- mul_reset=1 while reset is high.
- ready=1 in the first cycle after reset is released.
- All outputs are registered except mul_reset (= reset | state==CLR) and ready (= state==IDLE).
- FSM states: IDLE, CLR, RUN, DRAIN, CAPTURE.
- IDLE, req & funct==MULTU: latch opA/opB into mul_dataA/B; go to CLR.
- IDLE, req & MFHI/MFLO: next cycle rd_data=hi or lo, rd_valid=1; stay IDLE.
- IDLE, req with any other funct: no effect.
- CLR: mul_reset=1, mul_signal=0, one cycle; go to RUN with counter=0.
- RUN: mul_signal=25 for exactly ITER cycles; counter increments each cycle; go to DRAIN when counter==ITER-1.
- DRAIN: mul_signal=63 for one cycle.
- CAPTURE: mul_signal=0; sample mul_dataOut; hi<=[2W-1:W], lo<=[W-1:0]; go to IDLE; done=1 in the following cycle.
- Latency: acceptance edge to hi/lo/done visible = ITER+3 edges (35 at default).
- Next request accepted in the cycle done is high.
- mul_dataA/B are held stable from acceptance through CAPTURE.
- req while ready=0 is ignored, not queued; upstream must hold req until ready.
- MFHI/MFLO during a multiply therefore stall; they return the new result once done.
- reset in any state: immediate return to IDLE with reset values; in-flight product discarded; hi/lo cleared.
- rd_valid and done never assert in the same cycle.
- Product arithmetic is the multiplier's responsibility; no width extension or truncation here.

Optional Feature:
MTHILO_EN
- Defined: funct MTHI=17 / MTLO=19 with req in IDLE writes opA into hi / lo at that edge. Single cycle, no done pulse, ready stays 1.
- Undefined: MTHI/MTLO are treated as unknown funct with no effect; hi/lo are written only by CAPTURE and reset.

Decomposition:
- Shared package mips_alu_pkg:
  - funct constants MULTU=6'b011001, OUT=6'b111111, MFHI=6'b010000, MFLO=6'b010010, MTHI=6'b010001, MTLO=6'b010011
  - FSM state encoding
  - WIDTH default
- One sub-module, hilo_regs: HI/LO storage with capture, MT write and read-mux ports. FSM and counter stay in the top.

Test Plan:
- Reset, then MULTU opA=0xFFFFFFFF opB=0xFFFFFFFF -> mul_signal=25 for 32 cycles, 63 for 1; done 35 edges after acceptance; hi=0xFFFFFFFE, lo=0x00000001.
- Back-to-back MULTU 3*5 then 7*6 (second req held until ready) -> mul_reset pulses once per op; lo=15 then lo=42, hi=0 both times.
- After MULTU 0x80000000*4: MFHI -> rd_data=0x00000002 with rd_valid one cycle later; MFLO -> 0x00000000.
- MFLO asserted 5 cycles into a MULTU 6*7 -> ready=0, no rd_valid until done; held req then returns rd_data=42.
- reset asserted in RUN, counter=10 -> next cycle state IDLE, hi=lo=0, mul_signal=0, no done pulse; a following MULTU 2*3 gives lo=6.
- With MTHILO_EN: MTHI opA=0x12345678 -> hi=0x12345678 next cycle, no done. Without: same stimulus leaves hi unchanged.
